data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder_if.sv | 21 ++
 rtl/data_mem_responder.sv | 217 +++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Data-bus handshake between the core (master) and the data memory (slave).
// The tri-state data lines DDT are a plain inout pin on the responder; they
// are not part of this bundle.
interface data_mem_responder_if;
    logic        MREQ;      // request, active-high
    logic        WRITE;     // 1 = write, 0 = read
    logic [1:0]  SIZE;      // 00 byte, 01 halfword, 10 word, 11 illegal
    logic [31:0] DAD;       // byte address
    logic        ACKD_n;    // acknowledge, active-low, one cycle
    logic        MISALIGN;  // sticky misaligned/illegal access flag

    modport master (
        output MREQ, WRITE, SIZE, DAD,
        input  ACKD_n, MISALIGN
    );

    modport slave (
        input  MREQ, WRITE, SIZE, DAD,
        output ACKD_n, MISALIGN
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one core transaction, waits WAIT_CYCLES,
// then acknowledges for one cycle. A word-organised RAM with byte-lane
// writes backs it. Read data is right-justified and zero-extended, and it
// is driven onto DDT only in the acknowledge cycle of a read.
module data_mem_responder #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    data_mem_responder_if.slave       s_bus,
    inout  wire  [31:0]               DDT
);

    localparam int         DEPTH  = 2 ** ADDR_BITS;
    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [3:0]           r_cnt;
    logic [3:0]           w_cnt_next;

    // Request registers
    logic                 r_write;
    logic [1:0]           r_size;
    logic [ADDR_BITS+1:0] r_addr;
    logic [31:0]          r_wdata;

    // Output registers
    logic                 r_ackd_n;
    logic                 r_ddt_oe;
    logic                 r_misalign;
    logic [31:0]          r_rdata_q;

    logic [31:0]          r_mem [DEPTH];

    // Operands of the access performed on the edge entering ACK. With zero
    // wait cycles that edge is also the accepting edge, so the live bus
    // values are used; otherwise the latched request is used.
    logic                 w_op_write;
    logic [1:0]           w_op_size;
    logic [ADDR_BITS+1:0] w_op_addr;
    logic [31:0]          w_op_wdata;
    logic                 w_op_bad;
    logic                 w_enter_ack;
    logic [ADDR_BITS-1:0] w_word_idx;
    logic [3:0]           w_be;
    logic [31:0]          w_lane_data;
    logic [31:0]          w_rd_fmt;
    logic                 w_unused;

    // Halfwords must be 2-byte aligned, words 4-byte aligned; SIZE=11 is illegal.
    function automatic logic f_bad(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (size)
            2'b01:   bad = lo[0];
            2'b10:   bad = (lo != 2'b00);
            2'b11:   bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Right-justify and zero-extend the selected lane(s) of a RAM word.
    function automatic logic [31:0] f_format(input logic [31:0] word,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lo);
        logic [31:0] res;
        res = '0;
        case (size)
            2'b00: begin
                case (lo)
                    2'b00:   res = {24'b0, word[7:0]};
                    2'b01:   res = {24'b0, word[15:8]};
                    2'b10:   res = {24'b0, word[23:16]};
                    default: res = {24'b0, word[31:24]};
                endcase
            end
            2'b01:   res = lo[1] ? {16'b0, word[31:16]} : {16'b0, word[15:0]};
            2'b10:   res = word;
            default: res = '0;
        endcase
        return res;
    endfunction

    // Next-state and wait-counter logic
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (s_bus.MREQ) begin
                    w_cnt_next   = LP_WAIT;
                    w_state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_ACK;
                end
            end
            S_WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_next = S_ACK;
                end
            end
            S_ACK:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (rst) begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
        end
    end

    // Access decode: operand select, byte enables and lane-replicated write data
    always_comb begin
        w_op_write  = (r_state == S_IDLE) ? s_bus.WRITE                 : r_write;
        w_op_size   = (r_state == S_IDLE) ? s_bus.SIZE                  : r_size;
        w_op_addr   = (r_state == S_IDLE) ? s_bus.DAD[ADDR_BITS+1:0]    : r_addr;
        w_op_wdata  = (r_state == S_IDLE) ? DDT                         : r_wdata;
        w_op_bad    = f_bad(w_op_size, w_op_addr[1:0]);
        w_enter_ack = (w_state_next == S_ACK) && (r_state != S_ACK);
        w_word_idx  = w_op_addr[ADDR_BITS+1:2];
        w_be        = 4'b0000;
        w_lane_data = w_op_wdata;
        if (!w_op_bad) begin
            case (w_op_size)
                2'b00: begin
                    w_be        = 4'b0001 << w_op_addr[1:0];
                    w_lane_data = {4{w_op_wdata[7:0]}};
                end
                2'b01: begin
                    w_be        = w_op_addr[1] ? 4'b1100 : 4'b0011;
                    w_lane_data = {2{w_op_wdata[15:0]}};
                end
                default: w_be = 4'b1111;
            endcase
        end
    end

    // State and wait-counter registers
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Latch the request on the accepting edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (r_state == S_IDLE && s_bus.MREQ) begin
            r_write <= s_bus.WRITE;
            r_size  <= s_bus.SIZE;
            r_addr  <= s_bus.DAD[ADDR_BITS+1:0];
            r_wdata <= DDT;
        end
    end

    // RAM: byte-lane write and word read on the edge entering ACK
    always_ff @(posedge clk) begin
        // NOTE: the RAM array and its read register have no reset, so they
        // map onto block RAM; contents survive rst by design.
        if (w_enter_ack) begin
            if (w_op_write) begin
                for (int i = 0; i < 4; i++) begin
                    if (w_be[i]) begin
                        r_mem[w_word_idx][8*i +: 8] <= w_lane_data[8*i +: 8];
                    end
                end
            end else begin
                r_rdata_q <= r_mem[w_word_idx];
            end
        end
    end

    // Acknowledge, DDT enable and sticky misalign flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ackd_n   <= 1'b1;
            r_ddt_oe   <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_ackd_n <= !w_enter_ack;
            r_ddt_oe <= w_enter_ack && !w_op_write;
            if (w_enter_ack && w_op_bad) begin
                r_misalign <= 1'b1;
            end
        end
    end

    // In ACK the request registers hold the access being answered.
    assign w_rd_fmt = f_bad(r_size, r_addr[1:0]) ? 32'h0 : f_format(r_rdata_q, r_size, r_addr[1:0]);

    assign DDT            = r_ddt_oe ? w_rd_fmt : 32'bz;
    assign s_bus.ACKD_n   = r_ackd_n;
    assign s_bus.MISALIGN = r_misalign;

    // Address bits above the RAM depth are ignored (address wraps).
    assign w_unused = ^s_bus.DAD[31:ADDR_BITS+2];

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: three instances (WAIT_CYCLES
// 1, 0 and 3), a directed vector table, multi-cycle reset and back-to-back
// sequences, and randomized traffic against a byte-addressed memory model.
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-instance stimulus: index 0 -> WAIT_CYCLES=1, 1 -> 0, 2 -> 3
    logic        rst_v  [3];
    logic        mreq_v [3];
    logic        wr_v   [3];
    logic [1:0]  size_v [3];
    logic [31:0] dad_v  [3];
    logic        drv_v  [3];
    logic [31:0] wd_v   [3];

    data_mem_responder_if bus_a ();
    data_mem_responder_if bus_b ();
    data_mem_responder_if bus_c ();

    wire [31:0] ddt_a;
    wire [31:0] ddt_b;
    wire [31:0] ddt_c;

    assign bus_a.MREQ = mreq_v[0];
    assign bus_a.WRITE = wr_v[0];
    assign bus_a.SIZE = size_v[0];
    assign bus_a.DAD = dad_v[0];
    assign ddt_a = drv_v[0] ? wd_v[0] : 32'bz;

    assign bus_b.MREQ = mreq_v[1];
    assign bus_b.WRITE = wr_v[1];
    assign bus_b.SIZE = size_v[1];
    assign bus_b.DAD = dad_v[1];
    assign ddt_b = drv_v[1] ? wd_v[1] : 32'bz;

    assign bus_c.MREQ = mreq_v[2];
    assign bus_c.WRITE = wr_v[2];
    assign bus_c.SIZE = size_v[2];
    assign bus_c.DAD = dad_v[2];
    assign ddt_c = drv_v[2] ? wd_v[2] : 32'bz;

    data_mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .rst(rst_v[0]), .s_bus(bus_a), .DDT(ddt_a));
    data_mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst(rst_v[1]), .s_bus(bus_b), .DDT(ddt_b));
    data_mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(3)) u_dut_w3 (
        .clk(clk), .rst(rst_v[2]), .s_bus(bus_c), .DDT(ddt_c));

    function automatic int wait_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 0 : 3;
    endfunction

    function automatic logic get_ack(input int d);
        return (d == 0) ? bus_a.ACKD_n : (d == 1) ? bus_b.ACKD_n : bus_c.ACKD_n;
    endfunction

    function automatic logic get_mis(input int d);
        return (d == 0) ? bus_a.MISALIGN : (d == 1) ? bus_b.MISALIGN : bus_c.MISALIGN;
    endfunction

    function automatic logic [31:0] get_ddt(input int d);
        return (d == 0) ? ddt_a : (d == 1) ? ddt_b : ddt_c;
    endfunction

    // ---------------- reference model: byte-addressed memory ----------------
    logic [7:0] mb    [3][4096];
    bit         mis_m [3];

    function automatic bit is_bad(input logic [1:0] s, input logic [31:0] a);
        return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
    endfunction

    task automatic model_apply(input int d, input bit wr, input logic [1:0] s,
                               input logic [31:0] a, input logic [31:0] wd,
                               output logic [31:0] exp_rd);
        int b;
        int nb;
        b  = int'(a[11:0]);
        nb = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
        exp_rd = '0;
        if (is_bad(s, a)) begin
            mis_m[d] = 1'b1;
        end else if (wr) begin
            for (int i = 0; i < nb; i++) mb[d][b + i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < nb; i++) exp_rd[8*i +: 8] = mb[d][b + i];
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_released(input string name, input int d);
        logic [31:0] v;
        v = get_ddt(d);
        n_checks++;
        if (!($isunknown(v) || v == 32'h0)) begin
            n_fail++;
            $display("FAIL %s: DDT driven with %h, expected released", name, v);
        end
    endtask

    // ---------------- bus driver ----------------
    task automatic start_req(input int d, input bit wr, input logic [1:0] s,
                             input logic [31:0] a, input logic [31:0] wd);
        mreq_v[d] = 1'b1;
        wr_v[d]   = wr;
        size_v[d] = s;
        dad_v[d]  = a;
        drv_v[d]  = wr;
        wd_v[d]   = wd;
    endtask

    // Waits for the accepting edge, then for ACKD_n low (bounded). lat counts
    // cycles after the accepting edge; 0 means the bound expired.
    task automatic wait_ack(input int d, input bit is_read,
                            output logic [31:0] rd, output int lat);
        lat = 0;
        rd  = '0;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (get_ack(d) == 1'b0) begin
                lat = k;
                rd  = get_ddt(d);
                break;
            end
            if (is_read) check_released("ddt_before_ack", d);
        end
        mreq_v[d] = 1'b0;
        drv_v[d]  = 1'b0;
    endtask

    task automatic txn(input int d, input bit wr, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output int lat);
        @(negedge clk);
        start_req(d, wr, s, a, wd);
        wait_ack(d, !wr, rd, lat);
        if (!wr && lat > 0) begin
            @(negedge clk);
            check_released("ddt_after_ack", d);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int          d;
        bit          wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_mis;
    } vec_t;

    function automatic vec_t mk(input int d, input bit wr, input logic [1:0] s,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] er, input bit em);
        vec_t v;
        v.d = d; v.wr = wr; v.size = s; v.addr = a;
        v.wdata = wd; v.exp_rd = er; v.exp_mis = em;
        return v;
    endfunction

    task automatic run_random(input int d, input int n);
        logic [31:0] a, wd, rd, er;
        logic [1:0]  s;
        bit          wr;
        int          lat;
        for (int i = 0; i < 16; i++) begin
            a  = 32'h800 + 32'(i * 4);
            wd = $urandom;
            txn(d, 1'b1, 2'b10, a, wd, rd, lat);
            model_apply(d, 1'b1, 2'b10, a, wd, er);
        end
        for (int i = 0; i < n; i++) begin
            a  = 32'h800 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 7)) << 12);
            s  = 2'($urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            if (s == 2'b00) wd = wd & 32'hFF;
            if (s == 2'b01) wd = wd & 32'hFFFF;
            txn(d, wr, s, a, wd, rd, lat);
            model_apply(d, wr, s, a, wd, er);
            check("rand_latency", 32'(lat), 32'(wait_of(d) + 1));
            if (!wr) check("rand_rdata", rd, er);
            check("rand_misalign", 32'(get_mis(d)), 32'(mis_m[d]));
        end
    endtask

    task automatic period_test(input int d);
        int last;
        int lows;
        last = -1;
        lows = 0;
        @(negedge clk);
        start_req(d, 1'b0, 2'b10, 32'h800, 32'h0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (get_ack(d) == 1'b0) begin
                if (lows > 0) check("ack_period", 32'(k - last), 32'(wait_of(d) + 2));
                lows++;
                last = k;
                if (lows == 4) break;
            end
        end
        mreq_v[d] = 1'b0;
        check("ack_pulse_count", 32'(lows), 32'd4);
    endtask

    initial begin
        vec_t        vt [$];
        logic [31:0] rd, er;
        int          lat;
        int          lows;

        for (int d = 0; d < 3; d++) begin
            rst_v[d] = 1'b1; mreq_v[d] = 1'b0; wr_v[d] = 1'b0; size_v[d] = 2'b00;
            dad_v[d] = '0; drv_v[d] = 1'b0; wd_v[d] = '0; mis_m[d] = 1'b0;
        end

        vt.push_back(mk(0, 1, 2'b10, 32'h100,  32'hDEADBEEF, 32'h0,        0));
        vt.push_back(mk(0, 0, 2'b10, 32'h100,  32'h0,        32'hDEADBEEF, 0));
        vt.push_back(mk(0, 1, 2'b10, 32'h200,  32'h0,        32'h0,        0));
        vt.push_back(mk(0, 1, 2'b00, 32'h200,  32'h11,       32'h0,        0));
        vt.push_back(mk(0, 1, 2'b00, 32'h201,  32'h22,       32'h0,        0));
        vt.push_back(mk(0, 1, 2'b00, 32'h202,  32'h33,       32'h0,        0));
        vt.push_back(mk(0, 1, 2'b00, 32'h203,  32'h44,       32'h0,        0));
        vt.push_back(mk(0, 0, 2'b10, 32'h200,  32'h0,        32'h44332211, 0));
        vt.push_back(mk(0, 0, 2'b01, 32'h202,  32'h0,        32'h00004433, 0));
        vt.push_back(mk(0, 0, 2'b00, 32'h203,  32'h0,        32'h00000044, 0));
        vt.push_back(mk(0, 0, 2'b00, 32'h201,  32'h0,        32'h00000022, 0));
        vt.push_back(mk(0, 0, 2'b01, 32'h200,  32'h0,        32'h00002211, 0));
        vt.push_back(mk(0, 1, 2'b10, 32'h300,  32'h12345678, 32'h0,        0));
        vt.push_back(mk(0, 1, 2'b01, 32'h301,  32'hBEEF,     32'h0,        1));
        vt.push_back(mk(0, 0, 2'b10, 32'h300,  32'h0,        32'h12345678, 1));
        vt.push_back(mk(0, 0, 2'b10, 32'h302,  32'h0,        32'h0,        1));
        vt.push_back(mk(0, 1, 2'b10, 32'h1004, 32'hA5A55A5A, 32'h0,        1));
        vt.push_back(mk(0, 0, 2'b10, 32'h004,  32'h0,        32'hA5A55A5A, 1));
        vt.push_back(mk(1, 1, 2'b10, 32'h010,  32'h0BADF00D, 32'h0,        0));
        vt.push_back(mk(1, 0, 2'b10, 32'h010,  32'h0,        32'h0BADF00D, 0));
        vt.push_back(mk(1, 1, 2'b00, 32'h012,  32'h77,       32'h0,        0));
        vt.push_back(mk(1, 0, 2'b10, 32'h010,  32'h0,        32'h0B77F00D, 0));
        vt.push_back(mk(1, 0, 2'b11, 32'h010,  32'h0,        32'h0,        1));
        vt.push_back(mk(1, 0, 2'b10, 32'h010,  32'h0,        32'h0B77F00D, 1));

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("reset_ackd_n", 32'(get_ack(d)), 32'd1);
            check("reset_misalign", 32'(get_mis(d)), 32'd0);
            check_released("reset_ddt", d);
            rst_v[d] = 1'b0;
        end

        // Directed table
        foreach (vt[i]) begin
            txn(vt[i].d, vt[i].wr, vt[i].size, vt[i].addr, vt[i].wdata, rd, lat);
            model_apply(vt[i].d, vt[i].wr, vt[i].size, vt[i].addr, vt[i].wdata, er);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(wait_of(vt[i].d) + 1));
            if (!vt[i].wr) check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            check($sformatf("vec%0d_misalign", i), 32'(get_mis(vt[i].d)), 32'(vt[i].exp_mis));
        end

        // Back-to-back requests with MREQ held high
        period_test(1);
        period_test(2);

        // Reset one cycle after accepting a write: the write is lost
        txn(2, 1'b1, 2'b10, 32'h40, 32'h11112222, rd, lat);
        model_apply(2, 1'b1, 2'b10, 32'h40, 32'h11112222, er);
        @(negedge clk);
        start_req(2, 1'b1, 2'b10, 32'h40, 32'hCAFEF00D);
        @(posedge clk);
        @(negedge clk);
        rst_v[2] = 1'b1; mreq_v[2] = 1'b0; drv_v[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_v[2] = 1'b0;
        mis_m[2] = 1'b0;
        lows = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (get_ack(2) == 1'b0) lows++;
        end
        check("rst_early_no_ack", 32'(lows), 32'd0);
        check("rst_early_misalign", 32'(get_mis(2)), 32'd0);
        txn(2, 1'b0, 2'b10, 32'h40, 32'h0, rd, lat);
        model_apply(2, 1'b0, 2'b10, 32'h40, 32'h0, er);
        check("rst_early_old_data", rd, er);

        // Reset in the ACK cycle: the write has already committed
        @(negedge clk);
        start_req(2, 1'b1, 2'b10, 32'h40, 32'hCAFEF00D);
        wait_ack(2, 1'b0, rd, lat);
        check("rst_ack_latency", 32'(lat), 32'd4);
        rst_v[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_v[2] = 1'b0;
        check("rst_ack_ackd_n", 32'(get_ack(2)), 32'd1);
        model_apply(2, 1'b1, 2'b10, 32'h40, 32'hCAFEF00D, er);
        mis_m[2] = 1'b0;
        txn(2, 1'b0, 2'b10, 32'h40, 32'h0, rd, lat);
        check("rst_ack_new_data", rd, 32'hCAFEF00D);

        // Request held across reset release is accepted on the first free edge
        @(negedge clk);
        rst_v[0] = 1'b1;
        start_req(0, 1'b0, 2'b10, 32'h100, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_v[0] = 1'b0;
        mis_m[0] = 1'b0;
        check("held_req_misalign_cleared", 32'(get_mis(0)), 32'd0);
        wait_ack(0, 1'b1, rd, lat);
        check("held_req_latency", 32'(lat), 32'd2);
        check("held_req_rdata", rd, 32'hDEADBEEF);

        // Randomized traffic against the model
        run_random(0, 60);
        run_random(2, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
